// File: rtl/keycode_event_queue.sv
// keycode_event_queue
// Watches NUM_CH raw HID keycode slots and turns changes in the held-key set
// into ordered press/release events. Consumers read the events through a
// small valid/ready FIFO, so they never have to poll the raw slots.
// Zero slots and repeated codes within one sample are ignored. A scan first
// emits every release in slot order and then every press in slot order.
module keycode_event_queue #(
    parameter int NUM_CH     = 4,
    parameter int KEY_W      = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    input  logic [NUM_CH*KEY_W-1:0]     kc_in,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [KEY_W-1:0]            evt_code,
    output logic                        evt_press,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [$clog2(NUM_CH+1)-1:0] keys_held,
    output logic                        busy,
    output logic                        ovf,
    input  logic                        ovf_clr
);

    localparam int VW = NUM_CH * KEY_W;
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int HW = $clog2(NUM_CH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN_REL,
        S_SCAN_PRS
    } state_t;

    // Returns the keycode held in slot i of a packed slot vector.
    function automatic logic [KEY_W-1:0] slotOf(input logic [VW-1:0] v, input int i);
        return v[i*KEY_W +: KEY_W];
    endfunction

    // A slot counts only if it is nonzero and is the first slot holding its code.
    function automatic logic isEffective(input logic [VW-1:0] v, input int i);
        logic [KEY_W-1:0] code;
        logic             eff;
        code = slotOf(v, i);
        eff  = (code != '0);
        for (int j = 0; j < NUM_CH; j++) begin
            if (j < i && slotOf(v, j) == code) begin
                eff = 1'b0;
            end
        end
        return eff;
    endfunction

    // True when the given code appears in any slot of the vector.
    function automatic logic containsCode(input logic [VW-1:0] v, input logic [KEY_W-1:0] code);
        logic found;
        found = 1'b0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (slotOf(v, j) == code) begin
                found = 1'b1;
            end
        end
        return found;
    endfunction

    // Number of distinct nonzero codes in a slot vector.
    function automatic logic [HW-1:0] countEffective(input logic [VW-1:0] v);
        logic [HW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (isEffective(v, i)) begin
                cnt = cnt + HW'(1);
            end
        end
        return cnt;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [VW-1:0]      r_kc_q;
    logic [VW-1:0]      r_snap;
    logic [VW-1:0]      r_new_q;
    logic [IW-1:0]      r_idx;
    logic [HW-1:0]      r_keys_held;

    logic               w_latch;
    logic               w_commit;
    logic               w_push;
    logic [KEY_W-1:0]   w_push_code;
    logic               w_push_press;
    logic               w_idx_last;
    logic [KEY_W-1:0]   w_snap_code;
    logic [KEY_W-1:0]   w_new_code;

    logic [KEY_W:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [LW-1:0]      r_level;
    logic               r_ovf;
    logic               r_evt_valid;
    logic [KEY_W-1:0]   r_evt_code;
    logic               r_evt_press;

    logic               w_pop;
    logic               w_full;
    logic               w_push_ok;
    logic               w_drop;
    logic [AW-1:0]      w_rd_next;
    logic [LW-1:0]      w_remain;

    assign w_idx_last  = (r_idx == IW'(NUM_CH - 1));
    assign w_snap_code = slotOf(r_snap, int'(r_idx));
    assign w_new_code  = slotOf(r_new_q, int'(r_idx));

    // Scan state register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Scan sequencing: latch a changed set, walk old slots for releases, then new slots for presses.
    always_comb begin
        w_state_nxt  = r_state;
        w_latch      = 1'b0;
        w_commit     = 1'b0;
        w_push       = 1'b0;
        w_push_code  = '0;
        w_push_press = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_kc_q != r_snap) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_SCAN_REL;
                end
            end
            S_SCAN_REL: begin
                if (isEffective(r_snap, int'(r_idx)) && !containsCode(r_new_q, w_snap_code)) begin
                    w_push       = 1'b1;
                    w_push_code  = w_snap_code;
                    w_push_press = 1'b0;
                end
                if (w_idx_last) begin
                    w_state_nxt = S_SCAN_PRS;
                end
            end
            S_SCAN_PRS: begin
                if (isEffective(r_new_q, int'(r_idx)) && !containsCode(r_snap, w_new_code)) begin
                    w_push       = 1'b1;
                    w_push_code  = w_new_code;
                    w_push_press = 1'b1;
                end
                if (w_idx_last) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Input sampling, latched scan target, slot index and committed snapshot.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_kc_q      <= '0;
            r_snap      <= '0;
            r_new_q     <= '0;
            r_idx       <= '0;
            r_keys_held <= '0;
        end else begin
            r_kc_q <= kc_in;
            if (w_latch) begin
                r_new_q <= r_kc_q;
                r_idx   <= '0;
            end else if (r_state != S_IDLE) begin
                r_idx <= w_idx_last ? '0 : r_idx + IW'(1);
            end
            if (w_commit) begin
                r_snap      <= r_new_q;
                r_keys_held <= countEffective(r_new_q);
            end
        end
    end

    assign w_pop     = r_evt_valid & evt_ready;
    assign w_full    = (r_level == LW'(FIFO_DEPTH));
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;
    assign w_rd_next = r_rd_ptr + AW'(w_pop);
    assign w_remain  = r_level - LW'(w_pop);

    // FIFO pointers, occupancy and the sticky overflow flag (a drop beats a clear).
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_level  <= r_level + LW'(w_push_ok) - LW'(w_pop);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Event storage; a slot is written only when it is free or its old entry is popping.
    always_ff @(posedge clk_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {w_push_press, w_push_code};
        end
    end

    // Registered head: shows the oldest entry already stored before this edge and holds while stalled or empty.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_evt_valid <= 1'b0;
            r_evt_code  <= '0;
            r_evt_press <= 1'b0;
        end else begin
            r_evt_valid <= (w_remain != '0);
            if (w_remain != '0) begin
                r_evt_code  <= r_mem[w_rd_next][KEY_W-1:0];
                r_evt_press <= r_mem[w_rd_next][KEY_W];
            end
        end
    end

    assign evt_valid  = r_evt_valid;
    assign evt_code   = r_evt_code;
    assign evt_press  = r_evt_press;
    assign fifo_level = r_level;
    assign keys_held  = r_keys_held;
    assign busy       = (r_state != S_IDLE);
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_keycode_event_queue.sv
// Testbench for keycode_event_queue (NUM_CH=4, KEY_W=8, FIFO_DEPTH=2).
// A set-level reference model predicts every output each cycle, and directed
// scenarios pin the event streams with hand-computed literals.
module tb_keycode_event_queue;

    localparam int NUM_CH     = 4;
    localparam int KEY_W      = 8;
    localparam int FIFO_DEPTH = 2;

    logic        clk_clk       = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic [31:0] kc_in         = '0;
    logic        evt_ready     = 1'b0;
    logic        ovf_clr       = 1'b0;
    logic        evt_valid;
    logic [7:0]  evt_code;
    logic        evt_press;
    logic [1:0]  fifo_level;
    logic [2:0]  keys_held;
    logic        busy;
    logic        ovf;

    int nChecks = 0;
    int nFails  = 0;

    keycode_event_queue #(
        .NUM_CH    (NUM_CH),
        .KEY_W     (KEY_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .kc_in        (kc_in),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_press    (evt_press),
        .fifo_level   (fifo_level),
        .keys_held    (keys_held),
        .busy         (busy),
        .ovf          (ovf),
        .ovf_clr      (ovf_clr)
    );

    // Free-running clock.
    always #5 clk_clk = ~clk_clk;

    typedef struct {
        logic [7:0] code;
        logic       press;
        int         edgeNo;
    } ev_t;

    typedef struct {
        logic [7:0] code;
        logic       press;
    } obs_t;

    // Reference model state.
    ev_t         mFifo[$];
    logic [31:0] mKcQ, mSnap, mNew;
    bit          mScanning;
    int          mScanT;
    bit          pendValid [2*NUM_CH];
    logic [7:0]  pendCode  [2*NUM_CH];
    bit          pendPress [2*NUM_CH];
    bit          mValid;
    logic [7:0]  mCode;
    bit          mPress;
    bit          mOvf;
    int          mKeysHeld;
    int          edgeCount;

    // Events actually handed to the consumer.
    obs_t gotQ[$];

    function automatic logic [7:0] slotOf(input logic [31:0] v, input int i);
        return v[i*8 +: 8];
    endfunction

    function automatic bit inSet(input logic [31:0] v, input logic [7:0] code);
        for (int j = 0; j < NUM_CH; j++) if (slotOf(v, j) == code) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit firstOccurrence(input logic [31:0] v, input int i);
        if (slotOf(v, i) == 8'h00) return 1'b0;
        for (int j = 0; j < i; j++) if (slotOf(v, j) == slotOf(v, i)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int countDistinct(input logic [31:0] v);
        int n = 0;
        for (int i = 0; i < NUM_CH; i++) if (firstOccurrence(v, i)) n++;
        return n;
    endfunction

    task automatic resetModel();
        mFifo.delete();
        mKcQ = '0; mSnap = '0; mNew = '0;
        mScanning = 0; mScanT = 0;
        mValid = 0; mCode = '0; mPress = 0; mOvf = 0; mKeysHeld = 0;
        for (int i = 0; i < 2*NUM_CH; i++) begin
            pendValid[i] = 0; pendCode[i] = '0; pendPress[i] = 0;
        end
    endtask

    // Releases leave the set in the old set's slot order; presses then join in the new set's slot order.
    task automatic buildSchedule();
        for (int i = 0; i < NUM_CH; i++) begin
            pendValid[i]          = firstOccurrence(mSnap, i) && !inSet(mNew, slotOf(mSnap, i));
            pendCode[i]           = slotOf(mSnap, i);
            pendPress[i]          = 1'b0;
            pendValid[NUM_CH + i] = firstOccurrence(mNew, i) && !inSet(mSnap, slotOf(mNew, i));
            pendCode[NUM_CH + i]  = slotOf(mNew, i);
            pendPress[NUM_CH + i] = 1'b1;
        end
    endtask

    task automatic stepModel();
        bit   pop, pushReq, drop;
        int   sizeBefore;
        ev_t  e;
        edgeCount++;
        pop        = mValid && evt_ready;
        pushReq    = mScanning && pendValid[mScanT];
        sizeBefore = mFifo.size();
        if (pop) void'(mFifo.pop_front());
        drop = 0;
        if (pushReq) begin
            if (sizeBefore == FIFO_DEPTH && !pop) drop = 1;
            else begin
                e.code = pendCode[mScanT]; e.press = pendPress[mScanT]; e.edgeNo = edgeCount;
                mFifo.push_back(e);
            end
        end
        if (drop) mOvf = 1;
        else if (ovf_clr) mOvf = 0;
        if (mScanning) begin
            mScanT++;
            if (mScanT == 2*NUM_CH) begin
                mSnap     = mNew;
                mKeysHeld = countDistinct(mNew);
                mScanning = 0;
            end
        end else if (mKcQ != mSnap) begin
            mNew = mKcQ;
            buildSchedule();
            mScanning = 1;
            mScanT    = 0;
        end
        mKcQ = kc_in;
        if (mFifo.size() > 0 && mFifo[0].edgeNo < edgeCount) begin
            mValid = 1; mCode = mFifo[0].code; mPress = mFifo[0].press;
        end else begin
            mValid = 0;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] kc, input logic rdy, input logic clr);
        kc_in     = kc;
        evt_ready = rdy;
        ovf_clr   = clr;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic settle(input string name);
        int quiet = 0;
        int cycles = 0;
        tick(3);
        while (quiet < 4 && cycles < 200) begin
            tick(1);
            cycles++;
            if (!busy && !evt_valid && fifo_level == 0) quiet++;
            else quiet = 0;
        end
        checkOutput({name, "_settle"}, 32'(quiet >= 4), 1);
    endtask

    task automatic checkGot(input string name, input int idx, input logic [7:0] code, input logic press);
        if (idx < gotQ.size()) begin
            checkOutput({name, "_code"}, gotQ[idx].code, code);
            checkOutput({name, "_press"}, gotQ[idx].press, press);
        end else begin
            checkOutput({name, "_present"}, gotQ.size(), idx + 1);
        end
    endtask

    // Model advances on every active edge and resets asynchronously with the DUT.
    initial begin
        edgeCount = 0;
        resetModel();
        forever begin
            @(posedge clk_clk or negedge reset_reset_n);
            if (!reset_reset_n) resetModel();
            else stepModel();
        end
    end

    // Every cycle, compare all outputs with the model on the inactive edge and log accepted events.
    initial begin
        forever begin
            @(negedge clk_clk);
            checkOutput("cmp_valid", evt_valid, mValid);
            checkOutput("cmp_code",  evt_code,  mCode);
            checkOutput("cmp_press", evt_press, mPress);
            checkOutput("cmp_level", fifo_level, mFifo.size());
            checkOutput("cmp_keys",  keys_held, mKeysHeld);
            checkOutput("cmp_busy",  busy, mScanning);
            checkOutput("cmp_ovf",   ovf, mOvf);
            if (reset_reset_n && evt_valid && evt_ready) begin
                obs_t o;
                o.code = evt_code; o.press = evt_press;
                gotQ.push_back(o);
            end
        end
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios.
    initial begin
        int busyCycles;
        logic [7:0] expCode [8];
        bit         expPress[8];

        applyStimulus(32'h0, 1'b1, 1'b0);
        tick(3);
        checkOutput("rst_valid", evt_valid, 0);
        checkOutput("rst_level", fifo_level, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ovf", ovf, 0);
        checkOutput("rst_code", evt_code, 0);
        reset_reset_n = 1'b1;
        tick(2);

        $display("[TB] reset during release scan");
        applyStimulus(32'h0000_0004, 1'b1, 1'b0);
        tick(3);
        checkOutput("midscan_busy", busy, 1);
        #2 reset_reset_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_valid", evt_valid, 0);
        checkOutput("midrst_level", fifo_level, 0);
        checkOutput("midrst_keys", keys_held, 0);
        checkOutput("midrst_ovf", ovf, 0);
        gotQ.delete();
        tick(1);
        reset_reset_n = 1'b1;
        settle("t1");
        checkOutput("t1_count", gotQ.size(), 1);
        checkGot("t1_ev0", 0, 8'h04, 1'b1);
        checkOutput("t1_keys", keys_held, 1);

        $display("[TB] single press and release latency");
        applyStimulus(32'h0, 1'b1, 1'b0);
        settle("t2a");
        gotQ.delete();
        applyStimulus(32'h0000_0004, 1'b1, 1'b0);
        tick(7);
        checkOutput("lat_k7_valid", evt_valid, 0);
        tick(1);
        checkOutput("lat_k8_valid", evt_valid, 1);
        checkOutput("lat_k8_code", evt_code, 8'h04);
        checkOutput("lat_k8_press", evt_press, 1);
        settle("t2b");
        checkOutput("t2_press_count", gotQ.size(), 1);
        checkOutput("t2_keys1", keys_held, 1);
        gotQ.delete();
        applyStimulus(32'h0, 1'b1, 1'b0);
        settle("t2c");
        checkOutput("t2_rel_count", gotQ.size(), 1);
        checkGot("t2_rel", 0, 8'h04, 1'b0);
        checkOutput("t2_keys0", keys_held, 0);

        $display("[TB] duplicates and permutation");
        applyStimulus(32'h0000_1A04, 1'b1, 1'b0);
        settle("t3a");
        gotQ.delete();
        applyStimulus(32'h0007_071A, 1'b1, 1'b0);
        settle("t3b");
        checkOutput("t3_count", gotQ.size(), 2);
        checkGot("t3_ev0", 0, 8'h04, 1'b0);
        checkGot("t3_ev1", 1, 8'h07, 1'b1);
        checkOutput("t3_keys", keys_held, 2);
        gotQ.delete();
        applyStimulus(32'h0000_1A07, 1'b1, 1'b0);
        busyCycles = 0;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            if (busy) busyCycles++;
        end
        checkOutput("t3_perm_busy_cycles", busyCycles, 8);
        settle("t3c");
        checkOutput("t3_perm_count", gotQ.size(), 0);
        checkOutput("t3_perm_keys", keys_held, 2);

        $display("[TB] overflow and stall");
        applyStimulus(32'h0, 1'b1, 1'b0);
        settle("t4a");
        gotQ.delete();
        applyStimulus(32'h0706_0504, 1'b0, 1'b0);
        tick(14);
        checkOutput("t4_ovf", ovf, 1);
        checkOutput("t4_level", fifo_level, 2);
        checkOutput("t4_head_code", evt_code, 8'h04);
        checkOutput("t4_head_press", evt_press, 1);
        applyStimulus(32'h0706_0504, 1'b0, 1'b1);
        tick(1);
        checkOutput("t4_ovf_clr", ovf, 0);
        applyStimulus(32'h0706_0504, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checkOutput("t4_hold_valid", evt_valid, 1);
            checkOutput("t4_hold_code", evt_code, 8'h04);
        end

        $display("[TB] full FIFO with pop every cycle during scan");
        applyStimulus(32'h1312_1110, 1'b0, 1'b0);
        tick(2);
        applyStimulus(32'h1312_1110, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            checkOutput("t5_level", fifo_level, 2);
            checkOutput("t5_ovf", ovf, 0);
        end
        applyStimulus(32'h1312_1110, 1'b0, 1'b0);
        expCode  = '{8'h04, 8'h05, 8'h04, 8'h05, 8'h06, 8'h07, 8'h10, 8'h11};
        expPress = '{1, 1, 0, 0, 0, 0, 1, 1};
        checkOutput("t5_count", gotQ.size(), 8);
        for (int i = 0; i < 8; i++) checkGot("t5_ev", i, expCode[i], expPress[i]);
        tick(3);
        checkOutput("t5_rest_code", evt_code, 8'h12);
        applyStimulus(32'h1312_1110, 1'b1, 1'b0);
        settle("t5b");
        checkOutput("t5_total", gotQ.size(), 10);
        checkGot("t5_ev8", 8, 8'h12, 1'b1);
        checkGot("t5_ev9", 9, 8'h13, 1'b1);

        $display("[TB] input changes during scan");
        gotQ.delete();
        applyStimulus(32'h0000_0001, 1'b1, 1'b0);
        tick(3);
        applyStimulus(32'h0000_0002, 1'b1, 1'b0);
        tick(2);
        applyStimulus(32'h0000_1003, 1'b1, 1'b0);
        settle("t6");
        expCode  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h01, 8'h01, 8'h03, 8'h10};
        expPress = '{0, 0, 0, 0, 1, 0, 1, 1};
        checkOutput("t6_count", gotQ.size(), 8);
        for (int i = 0; i < 8; i++) checkGot("t6_ev", i, expCode[i], expPress[i]);
        checkOutput("t6_keys", keys_held, 2);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
